// File: rtl/onemhz_bus_pkg.sv
// Shared definitions for the 1MHz bus host initiator.
package onemhz_bus_pkg;

  localparam int unsigned DEF_CLK_DIV    = 50;
  localparam int unsigned DEF_LOW_CYCLES = 25;

  localparam logic PAGE_FRED = 1'b0;
  localparam logic PAGE_JIM  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CYCLE
  } state_t;

endpackage

// File: rtl/onemhz_clke_gen.sv
// Free-running 1MHz bus clock generator: phase counter, registered clke,
// and period-wrap / clke-rise phase strobes.
module onemhz_clke_gen
  import onemhz_bus_pkg::*;
#(
  parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
  parameter int unsigned LOW_CYCLES = DEF_LOW_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_clke,
  output logic o_wrap,
  output logic o_rise
);

  localparam int unsigned PW = $clog2(CLK_DIV);

  logic [PW-1:0] r_phase;
  logic [PW-1:0] w_phase_nxt;
  logic          w_wrap;
  logic          r_clke;

  // Next phase and phase-position strobes.
  always_comb begin
    w_wrap      = (r_phase == PW'(CLK_DIV - 1));
    w_phase_nxt = w_wrap ? '0 : (r_phase + PW'(1));
  end

  // Phase counter; clke is registered from the next phase so it is high
  // exactly while the phase sits in the upper LOW_CYCLES..CLK_DIV-1 window.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phase <= '0;
      r_clke  <= 1'b0;
    end else begin
      r_phase <= w_phase_nxt;
      r_clke  <= (w_phase_nxt >= PW'(LOW_CYCLES));
    end
  end

  assign o_clke = r_clke;
  assign o_wrap = w_wrap;
  assign o_rise = (r_phase == PW'(LOW_CYCLES - 1));

endmodule

// File: rtl/onemhz_bus_master.sv
// BBC 1MHz bus host initiator: single-byte FRED/JIM reads and writes
// aligned to the free-running clke period.
module onemhz_bus_master
  import onemhz_bus_pkg::*;
#(
  parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
  parameter int unsigned LOW_CYCLES = DEF_LOW_CYCLES
) (
  input  logic       clk50,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rnw,
  input  logic       cmd_page,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       clke,
  output logic       rnw,
  output logic       pgfc_n,
  output logic       pgfd_n,
  output logic [7:0] bus_addr,
  inout  logic [7:0] bus_data
);

  logic       w_wrap;
  logic       w_rise;
  logic       w_hs;
  logic       w_sel_rnw;
  logic       w_sel_page;
  logic [7:0] w_sel_addr;

  state_t     r_state;
  logic       r_rnw_l;
  logic       r_page_l;
  logic [7:0] r_addr_l;
  logic [7:0] r_wdata_l;
  logic       r_rnw;
  logic       r_pgfc_n;
  logic       r_pgfd_n;
  logic [7:0] r_bus_addr;
  logic       r_drive;
  logic       r_rsp_valid;
  logic [7:0] r_rdata;

  onemhz_clke_gen #(
    .CLK_DIV    (CLK_DIV),
    .LOW_CYCLES (LOW_CYCLES)
  ) u_clke_gen (
    .i_clk   (clk50),
    .i_rst_n (rst_n),
    .o_clke  (clke),
    .o_wrap  (w_wrap),
    .o_rise  (w_rise)
  );

  // Handshake, and the command fields used when entering CYCLE: straight
  // from the port when jumping IDLE->CYCLE, otherwise from the latch.
  always_comb begin
    w_hs       = cmd_valid && (r_state == ST_IDLE);
    w_sel_rnw  = (r_state == ST_IDLE) ? cmd_rnw   : r_rnw_l;
    w_sel_page = (r_state == ST_IDLE) ? cmd_page  : r_page_l;
    w_sel_addr = (r_state == ST_IDLE) ? cmd_addr  : r_addr_l;
  end

  // Transaction FSM with registered bus pins, write-drive enable and response.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_rnw_l     <= 1'b1;
      r_page_l    <= PAGE_FRED;
      r_addr_l    <= '0;
      r_wdata_l   <= '0;
      r_rnw       <= 1'b1;
      r_pgfc_n    <= 1'b1;
      r_pgfd_n    <= 1'b1;
      r_bus_addr  <= '0;
      r_drive     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      // Write data is held through phase 0 of the following period, which
      // is exactly the cycle carrying the response pulse.
      if (r_drive && r_rsp_valid) begin
        r_drive <= 1'b0;
      end
      unique case (r_state)
        ST_IDLE: begin
          if (w_hs) begin
            r_rnw_l   <= cmd_rnw;
            r_page_l  <= cmd_page;
            r_addr_l  <= cmd_addr;
            r_wdata_l <= cmd_wdata;
            if (w_wrap) begin
              r_state    <= ST_CYCLE;
              r_rnw      <= w_sel_rnw;
              r_pgfc_n   <= (w_sel_page != PAGE_FRED);
              r_pgfd_n   <= (w_sel_page != PAGE_JIM);
              r_bus_addr <= w_sel_addr;
            end else begin
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (w_wrap) begin
            r_state    <= ST_CYCLE;
            r_rnw      <= w_sel_rnw;
            r_pgfc_n   <= (w_sel_page != PAGE_FRED);
            r_pgfd_n   <= (w_sel_page != PAGE_JIM);
            r_bus_addr <= w_sel_addr;
          end
        end
        ST_CYCLE: begin
          if (w_rise && !r_rnw) begin
            r_drive <= 1'b1;
          end
          if (w_wrap) begin
            r_state     <= ST_IDLE;
            r_rnw       <= 1'b1;
            r_pgfc_n    <= 1'b1;
            r_pgfd_n    <= 1'b1;
            r_rsp_valid <= 1'b1;
            if (r_rnw) begin
              r_rdata <= bus_data;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = (r_state == ST_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign rnw       = r_rnw;
  assign pgfc_n    = r_pgfc_n;
  assign pgfd_n    = r_pgfd_n;
  assign bus_addr  = r_bus_addr;
  assign bus_data  = r_drive ? r_wdata_l : 'z;

endmodule

// File: tb/tb_onemhz_bus_master.sv
// Self-checking bench for onemhz_bus_master: vector table of transactions,
// response scoreboard, plus hand-written back-to-back and reset sequences.
module tb_onemhz_bus_master;

  localparam int DIV = 50;
  localparam int LOW = 25;

  typedef struct {
    logic       rnw;
    logic       page;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] resp;
    int         phase;
    logic [7:0] exp_rdata;
  } vec_t;

  logic       clk50     = 1'b0;
  logic       rst_n     = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_rnw   = 1'b1;
  logic       cmd_page  = 1'b0;
  logic [7:0] cmd_addr  = 8'h00;
  logic [7:0] cmd_wdata = 8'h00;
  logic       cmd_ready;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       clke;
  logic       rnw;
  logic       pgfc_n;
  logic       pgfd_n;
  logic [7:0] bus_addr;
  wire  [7:0] bus_data;

  logic [7:0] tb_resp = 8'h00;
  logic [7:0] last_wd = 8'h00;
  logic [7:0] sb_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int n_rsp = 0;
  int tb_phase;

  // Responder model: drives read data while clke is high during a read.
  assign bus_data = (clke && rnw && !(pgfc_n && pgfd_n)) ? tb_resp : 8'hzz;

  always #10 clk50 = ~clk50;

  onemhz_bus_master #(
    .CLK_DIV    (DIV),
    .LOW_CYCLES (LOW)
  ) dut (
    .clk50     (clk50),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_rnw   (cmd_rnw),
    .cmd_page  (cmd_page),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .clke      (clke),
    .rnw       (rnw),
    .pgfc_n    (pgfc_n),
    .pgfd_n    (pgfd_n),
    .bus_addr  (bus_addr),
    .bus_data  (bus_data)
  );

  // Reference phase: restarts at 0 on reset, counts 0..DIV-1.
  always @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) tb_phase <= 0;
    else        tb_phase <= (tb_phase == DIV - 1) ? 0 : tb_phase + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Scoreboard consumer: every response must match the oldest queued entry.
  always @(negedge clk50) begin
    if (rst_n && rsp_valid) begin
      n_rsp++;
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rsp_unexpected: got rsp_valid with rdata %0h expected none", rsp_rdata);
      end else begin
        check("rsp_rdata", 32'(rsp_rdata), 32'(sb_q.pop_front()));
        check("rsp_phase", 32'(tb_phase), 32'(0));
      end
    end
  end

  function automatic logic sel_n(input logic page);
    return page ? pgfd_n : pgfc_n;
  endfunction

  function automatic logic oth_n(input logic page);
    return page ? pgfc_n : pgfd_n;
  endfunction

  task automatic issue(input vec_t v, output int lat_exp);
    int k = 0;
    @(negedge clk50);
    while (!(cmd_ready && tb_phase == v.phase) && k < 300) begin
      @(negedge clk50);
      k++;
    end
    if (k >= 300) fail_now("issue_wait");
    cmd_valid = 1'b1;
    cmd_rnw   = v.rnw;
    cmd_page  = v.page;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    tb_resp   = v.resp;
    sb_q.push_back(v.exp_rdata);
    lat_exp = (tb_phase == DIV - 1) ? 1 : DIV - tb_phase;
    @(posedge clk50);
    #1;
    cmd_valid = 1'b0;
    cmd_rnw   = 1'($urandom);
    cmd_page  = 1'($urandom);
    cmd_addr  = 8'($urandom);
    cmd_wdata = 8'($urandom);
  endtask

  task automatic observe(input vec_t v, input int lat_exp);
    int lat = 0;
    int low = 0;
    int e_sig = 0;
    int e_data = 0;
    logic [7:0] wd;
    wd = v.rnw ? last_wd : v.wdata;
    while (lat < 200) begin
      @(negedge clk50);
      lat++;
      if (sel_n(v.page) == 1'b0) break;
    end
    check("strobe_latency", 32'(lat), 32'(lat_exp));
    check("strobe_start_phase", 32'(tb_phase), 32'(0));
    while (low < 200 && sel_n(v.page) == 1'b0) begin
      low++;
      if (oth_n(v.page) !== 1'b1 || rnw !== v.rnw || bus_addr !== v.addr) e_sig++;
      if (v.rnw) begin
        if (tb_phase >= LOW) begin
          if (bus_data !== v.resp) e_data++;
        end else if (bus_data === wd) e_data++;
      end else begin
        if (tb_phase >= LOW) begin
          if (bus_data !== v.wdata) e_data++;
        end else if (bus_data === wd) e_data++;
      end
      @(negedge clk50);
    end
    check("strobe_len", 32'(low), 32'(DIV));
    check("cycle_signal_errs", 32'(e_sig), 32'(0));
    check("cycle_data_errs", 32'(e_data), 32'(0));
    check("rnw_after", 32'(rnw), 32'(1));
    check("addr_hold", 32'(bus_addr), 32'(v.addr));
    if (v.rnw) check("read_no_drive_ph0", 32'(bus_data === wd), 32'(0));
    else       check("write_hold_ph0", 32'(bus_data), 32'(v.wdata));
    @(negedge clk50);
    check("data_released_ph1", 32'(bus_data === wd), 32'(0));
    if (!v.rnw) last_wd = v.wdata;
  endtask

  vec_t vecs[6];

  initial begin
    int le;
    int e;
    int rsp0;
    int k;
    vec_t w;

    vecs[0] = '{1'b0, 1'b0, 8'hFF, 8'hC9, 8'h00, 10, 8'h00};
    vecs[1] = '{1'b1, 1'b1, 8'h34, 8'h00, 8'h5A, 49, 8'h5A};
    vecs[2] = '{1'b0, 1'b0, 8'h12, 8'h33, 8'h00, 0,  8'h5A};
    vecs[3] = '{1'b1, 1'b0, 8'h80, 8'h00, 8'hA5, 24, 8'hA5};
    vecs[4] = '{1'b0, 1'b1, 8'h00, 8'h7E, 8'h00, 49, 8'hA5};
    vecs[5] = '{1'b1, 1'b1, 8'hFF, 8'h00, 8'h00, 48, 8'h00};

    // Reset and idle behaviour.
    repeat (100) @(negedge clk50);
    check("rst_cmd_ready", 32'(cmd_ready), 32'(1));
    check("rst_clke", 32'(clke), 32'(0));
    check("rst_rnw", 32'(rnw), 32'(1));
    check("rst_pgfc_n", 32'(pgfc_n), 32'(1));
    check("rst_pgfd_n", 32'(pgfd_n), 32'(1));
    check("rst_bus_addr", 32'(bus_addr), 32'(0));
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'(0));
    rst_n = 1'b1;
    e = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk50);
      if (clke !== (tb_phase >= LOW) || pgfc_n !== 1'b1 || pgfd_n !== 1'b1 ||
          cmd_ready !== 1'b1 || rsp_valid !== 1'b0) e++;
    end
    check("idle_errs", 32'(e), 32'(0));

    // Vector table: single transactions at chosen issue phases.
    for (int i = 0; i < 6; i++) begin
      issue(vecs[i], le);
      observe(vecs[i], le);
      repeat (2) @(negedge clk50);
    end
    check("sb_drained", 32'(sb_q.size()), 32'(0));

    // Back-to-back writes with cmd_valid held.
    begin
      int hs = 0;
      int runs = 0;
      int gap = 0;
      int len1 = 0;
      int len2 = 0;
      logic prev = 1'b1;
      bit sw = 1'b0;
      bit drop = 1'b0;
      rsp0 = n_rsp;
      @(negedge clk50);
      cmd_valid = 1'b1;
      cmd_rnw   = 1'b0;
      cmd_page  = 1'b0;
      cmd_addr  = 8'h11;
      cmd_wdata = 8'h22;
      for (int i = 0; i < 300; i++) begin
        if (sw) begin
          cmd_addr  = 8'h44;
          cmd_wdata = 8'h55;
          sw = 1'b0;
        end
        if (drop) begin
          cmd_valid = 1'b0;
          drop = 1'b0;
        end
        if (cmd_valid && cmd_ready) begin
          hs++;
          sb_q.push_back(8'h00);
          if (hs == 1) sw = 1'b1;
          else         drop = 1'b1;
        end
        if (pgfc_n == 1'b0) begin
          if (prev) runs++;
          if (runs == 1) len1++;
          if (runs == 2) len2++;
        end else if (runs == 1) begin
          gap++;
        end
        prev = pgfc_n;
        @(negedge clk50);
      end
      check("b2b_handshakes", 32'(hs), 32'(2));
      check("b2b_strobe_runs", 32'(runs), 32'(2));
      check("b2b_len1", 32'(len1), 32'(DIV));
      check("b2b_len2", 32'(len2), 32'(DIV));
      check("b2b_idle_gap", 32'(gap), 32'(DIV));
      check("b2b_rsp_count", 32'(n_rsp - rsp0), 32'(2));
      check("b2b_last_addr", 32'(bus_addr), 32'(8'h44));
      last_wd = 8'h55;
    end

    // Reset in the middle of a write.
    w = '{1'b0, 1'b0, 8'h66, 8'h99, 8'h00, 49, 8'h00};
    issue(w, le);
    k = 0;
    while (!(tb_phase == 30 && pgfc_n == 1'b0) && k < 200) begin
      @(negedge clk50);
      k++;
    end
    if (k >= 200) fail_now("midwrite_wait");
    check("midwrite_driving", 32'(bus_data), 32'(8'h99));
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("midrst_pgfc_n", 32'(pgfc_n), 32'(1));
    check("midrst_bus_released", 32'(bus_data === 8'h99), 32'(0));
    check("midrst_clke", 32'(clke), 32'(0));
    check("midrst_rnw", 32'(rnw), 32'(1));
    check("midrst_cmd_ready", 32'(cmd_ready), 32'(1));
    repeat (5) @(negedge clk50);
    rst_n = 1'b1;
    check("midrst_rdata", 32'(rsp_rdata), 32'(0));
    rsp0 = n_rsp;
    e = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk50);
      if (clke !== (tb_phase >= LOW) || pgfc_n !== 1'b1 || pgfd_n !== 1'b1 ||
          bus_data === 8'h99) e++;
    end
    check("post_rst_idle_errs", 32'(e), 32'(0));
    check("post_rst_no_rsp", 32'(n_rsp - rsp0), 32'(0));
    last_wd = 8'h99;
    w = '{1'b1, 1'b0, 8'h5C, 8'h00, 8'hC3, 7, 8'hC3};
    issue(w, le);
    observe(w, le);
    repeat (3) @(negedge clk50);
    check("final_sb_drained", 32'(sb_q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

endmodule
